pipe_datapath_fwd: RTL

- Parametrised five-stage (IF/ID/EX/MEM/WB) MIPS-subset pipeline for the processor top level.
- Successor to our first pipelined datapath, which had no hazard handling. Adds an internal main/ALU decoder, EX-stage forwarding, load-use stall, branch/jump flush and stall/flush counters.
- Instruction and data memories are external, combinational-read and word-addressed.

---
 rtl/pipe_datapath_fwd.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_datapath_fwd.sv
// Five-stage MIPS-subset pipeline with EX forwarding, load-use stall and branch/jump redirect.
// Instruction and data memories are external, combinational-read and word-addressed.
module pipe_datapath_fwd #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic [ADDR_W-1:0]        dmem_addr,
  output logic [DATA_W-1:0]        dmem_wdata,
  output logic                     dmem_we,
  input  logic [DATA_W-1:0]        dmem_rdata,
  output logic                     wb_we,
  output logic [$clog2(NREG)-1:0]  wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int RW = $clog2(NREG);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [RW-1:0]     rs;
    logic [RW-1:0]     rt;
    logic [RW-1:0]     rd;
    logic [ADDR_W-1:0] pc1;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata;
    logic [RW-1:0]     wreg;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] rdata;
    logic [RW-1:0]     wreg;
  } mem_wb_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc1_q, id_pc1_d;
  id_ex_t            ex_q, ex_d;
  ex_mem_t           mem_q, mem_d;
  mem_wb_t           wb_q, wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic [5:0]        id_op, id_funct;
  logic [4:0]        id_rs_f, id_rt_f, id_rd_f;
  logic [RW-1:0]     id_rs, id_rt, id_rd;
  logic [15:0]       id_imm16;
  ctrl_t             id_ctrl;
  logic              id_use_rs, id_use_rt, id_jump;
  logic [DATA_W-1:0] id_rd1, id_rd2;

  logic [DATA_W-1:0] ex_src_a, ex_fwd_b, ex_src_b, ex_alu;
  logic [RW-1:0]     ex_wreg;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              lu_hazard, stall, redirect;
  logic [DATA_W-1:0] wb_result;

  assign id_op    = id_instr_q[31:26];
  assign id_rs_f  = id_instr_q[25:21];
  assign id_rt_f  = id_instr_q[20:16];
  assign id_rd_f  = id_instr_q[15:11];
  assign id_imm16 = id_instr_q[15:0];
  assign id_funct = id_instr_q[5:0];
  assign id_rs    = id_rs_f[RW-1:0];
  assign id_rt    = id_rt_f[RW-1:0];
  assign id_rd    = id_rd_f[RW-1:0];

  always_comb begin
    id_ctrl   = '0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_jump   = 1'b0;
    case (id_op)
      6'h00: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.reg_dst   = 1'b1;
        id_use_rs         = 1'b1;
        id_use_rt         = 1'b1;
        case (id_funct)
          6'h20:   id_ctrl.alu_op = ALU_ADD;
          6'h22:   id_ctrl.alu_op = ALU_SUB;
          6'h24:   id_ctrl.alu_op = ALU_AND;
          6'h25:   id_ctrl.alu_op = ALU_OR;
          6'h2A:   id_ctrl.alu_op = ALU_SLT;
          default: begin
            id_ctrl   = '0;
            id_use_rs = 1'b0;
            id_use_rt = 1'b0;
          end
        endcase
      end
      6'h23: begin
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_use_rs          = 1'b1;
      end
      6'h2B: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_use_rs         = 1'b1;
        id_use_rt         = 1'b1;
      end
      6'h04: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.alu_op = ALU_SUB;
        id_use_rs      = 1'b1;
        id_use_rt      = 1'b1;
      end
      6'h08: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_use_rs         = 1'b1;
      end
      6'h02:   id_jump = 1'b1;
      default: id_ctrl = '0;
    endcase
  end

  // Register reads see a same-cycle WB write to the same register.
  always_comb begin
    id_rd1 = rf_q[id_rs];
    id_rd2 = rf_q[id_rt];
    if (wb_we && wb_addr == id_rs) id_rd1 = wb_result;
    if (wb_we && wb_addr == id_rt) id_rd2 = wb_result;
    if (id_rs == '0) id_rd1 = '0;
    if (id_rt == '0) id_rd2 = '0;
  end

  always_comb begin
    ex_src_a = ex_q.rd1;
    if (ex_q.rs != '0 && wb_q.reg_write && wb_q.wreg == ex_q.rs) ex_src_a = wb_result;
    if (ex_q.rs != '0 && mem_q.reg_write && mem_q.wreg == ex_q.rs) ex_src_a = mem_q.alu_out;
    ex_fwd_b = ex_q.rd2;
    if (ex_q.rt != '0 && wb_q.reg_write && wb_q.wreg == ex_q.rt) ex_fwd_b = wb_result;
    if (ex_q.rt != '0 && mem_q.reg_write && mem_q.wreg == ex_q.rt) ex_fwd_b = mem_q.alu_out;
    ex_src_b = ex_q.ctrl.alu_src ? ex_q.imm : ex_fwd_b;
    case (ex_q.ctrl.alu_op)
      ALU_SUB: ex_alu = ex_src_a - ex_src_b;
      ALU_AND: ex_alu = ex_src_a & ex_src_b;
      ALU_OR:  ex_alu = ex_src_a | ex_src_b;
      ALU_SLT: ex_alu = {{(DATA_W-1){1'b0}}, $signed(ex_src_a) < $signed(ex_src_b)};
      default: ex_alu = ex_src_a + ex_src_b;
    endcase
    ex_wreg      = ex_q.ctrl.reg_dst ? ex_q.rd : ex_q.rt;
    ex_taken     = ex_q.ctrl.branch && ((ex_src_a - ex_fwd_b) == '0);
    ex_br_target = ex_q.pc1 + ex_q.imm[ADDR_W-1:0];
  end

  // A taken branch squashes the ID consumer, so it also cancels any stall.
  always_comb begin
    lu_hazard = ex_q.ctrl.mem_to_reg && ex_q.rt != '0 &&
                ((id_use_rs && id_rs == ex_q.rt) || (id_use_rt && id_rt == ex_q.rt));
    stall     = lu_hazard && !ex_taken;
    redirect  = ex_taken || id_jump;
  end

  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (stall)    pc_d = pc_q;
    if (id_jump)  pc_d = id_instr_q[ADDR_W-1:0];
    if (ex_taken) pc_d = ex_br_target;

    id_instr_d = imem_rdata[31:0];
    id_pc1_d   = pc_q + ADDR_W'(1);
    if (stall) begin
      id_instr_d = id_instr_q;
      id_pc1_d   = id_pc1_q;
    end
    if (redirect) begin
      id_instr_d = '0;
      id_pc1_d   = '0;
    end

    ex_d.ctrl = id_ctrl;
    ex_d.rd1  = id_rd1;
    ex_d.rd2  = id_rd2;
    ex_d.imm  = {{(DATA_W-16){id_imm16[15]}}, id_imm16};
    ex_d.rs   = id_rs;
    ex_d.rt   = id_rt;
    ex_d.rd   = id_rd;
    ex_d.pc1  = id_pc1_q;
    if (stall || ex_taken) ex_d = '0;

    mem_d.reg_write  = ex_q.ctrl.reg_write;
    mem_d.mem_to_reg = ex_q.ctrl.mem_to_reg;
    mem_d.mem_write  = ex_q.ctrl.mem_write;
    mem_d.alu_out    = ex_alu;
    mem_d.wdata      = ex_fwd_b;
    mem_d.wreg       = ex_wreg;

    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.alu_out    = mem_q.alu_out;
    wb_d.rdata      = dmem_rdata;
    wb_d.wreg       = mem_q.wreg;

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      id_instr_q  <= '0;
      id_pc1_q    <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc1_q    <= id_pc1_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (wb_we) rf_q[wb_addr] <= wb_result;
    end
  end

  // Reset gates the memory and register writes of whatever is in flight.
  assign wb_result  = wb_q.mem_to_reg ? wb_q.rdata : wb_q.alu_out;
  assign imem_addr  = pc_q;
  assign dmem_addr  = mem_q.alu_out[ADDR_W-1:0];
  assign dmem_wdata = mem_q.wdata;
  assign dmem_we    = mem_q.mem_write && !reset;
  assign wb_we      = wb_q.reg_write && (wb_q.wreg != '0) && !reset;
  assign wb_addr    = wb_q.wreg;
  assign wb_data    = wb_result;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
